// File: rtl/rgb2gray_pkg.sv
// Shared types and constants for the RGB-to-grayscale stream converter.
// Mode encoding, default weights and the saturated-shift width helper.
package rgb2gray_pkg;

    typedef enum logic {
        GRAY_WEIGHTED = 1'b0,
        GRAY_MAX      = 1'b1
    } gray_mode_e;

    localparam int COEF_R_DEF    = 5;
    localparam int COEF_G_DEF    = 9;
    localparam int COEF_B_DEF    = 2;
    localparam int COEF_FRAC_DEF = 4;

    // Width of the rounded sum after dropping the fraction bits.
    function automatic int sat_shift_w(input int pix_w,
                                       input int coef_w,
                                       input int frac);
        return pix_w + coef_w + 2 - frac;
    endfunction

endpackage

// File: rtl/rgb2gray_stream_pipe_ctrl.sv
// Valid/advance chain for an N-stage pipeline with full backpressure.
// Stage k loads when it is empty or its successor is advancing.
module pipe_ctrl #(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic              out_ready_i,
    output logic              in_ready_o,
    output logic [STAGES-1:0] valid_o,
    output logic [STAGES-1:0] adv_o
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic              en_q;

    // Advance ripples back from the output handshake, last stage first.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !valid_q[STAGES-1] || out_ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    // Each advancing stage takes its predecessor's valid bit.
    always_comb begin
        valid_d = valid_q;
        if (adv[0]) begin
            valid_d[0] = in_valid_i && en_q;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    // Valid bits clear on reset; input side opens one cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            en_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            en_q    <= 1'b1;
        end
    end

    assign in_ready_o = en_q && adv[0];
    assign valid_o    = valid_q;
    assign adv_o      = adv;

endmodule

// File: rtl/rgb2gray_stream.sv
// Streamed RGB-to-gray converter: weighted sum with rounding and
// saturation, or per-beat max(R,G,B); three registered stages.
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int COEF_W    = 8,
    parameter int COEF_FRAC = COEF_FRAC_DEF,
    parameter int COEF_R    = COEF_R_DEF,
    parameter int COEF_G    = COEF_G_DEF,
    parameter int COEF_B    = COEF_B_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*PIX_W-1:0] in_rgb,
    input  logic               in_mode,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_gray,
    output logic               out_last
);

    localparam int PW  = PIX_W + COEF_W;
    localparam int SW  = PW + 2;
    localparam int SHW = sat_shift_w(PIX_W, COEF_W, COEF_FRAC);

    localparam logic [PW-1:0] CR  = PW'(COEF_R);
    localparam logic [PW-1:0] CG  = PW'(COEF_G);
    localparam logic [PW-1:0] CB  = PW'(COEF_B);
    localparam logic [SW-1:0] RND = SW'(1) << (COEF_FRAC - 1);

    if (COEF_FRAC < 1 || COEF_FRAC >= COEF_W) begin : g_bad_frac
        $error("rgb2gray_stream: COEF_FRAC must be in [1, COEF_W-1]");
    end

    logic [2:0] valid;
    logic [2:0] adv;

    pipe_ctrl #(
        .STAGES(3)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .out_ready_i(out_ready),
        .in_ready_o (in_ready),
        .valid_o    (valid),
        .adv_o      (adv)
    );

    logic [PIX_W-1:0] r, g, b, m_rg;
    assign r = in_rgb[3*PIX_W-1 -: PIX_W];
    assign g = in_rgb[2*PIX_W-1 -: PIX_W];
    assign b = in_rgb[PIX_W-1:0];

    // Stage 1 next state: channel products and the channel maximum.
    logic [PW-1:0]    pr_d, pg_d, pb_d;
    logic [PIX_W-1:0] max1_d;
    always_comb begin
        pr_d   = PW'(r) * CR;
        pg_d   = PW'(g) * CG;
        pb_d   = PW'(b) * CB;
        m_rg   = (r > g) ? r : g;
        max1_d = (m_rg > b) ? m_rg : b;
    end

    logic [PW-1:0]    pr_q, pg_q, pb_q;
    logic [PIX_W-1:0] max1_q;
    gray_mode_e       mode1_q;
    logic             last1_q;

    // Stage 1 register: products, max, mode and last travel together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr_q    <= '0;
            pg_q    <= '0;
            pb_q    <= '0;
            max1_q  <= '0;
            mode1_q <= GRAY_WEIGHTED;
            last1_q <= 1'b0;
        end else if (adv[0]) begin
            pr_q    <= pr_d;
            pg_q    <= pg_d;
            pb_q    <= pb_d;
            max1_q  <= max1_d;
            mode1_q <= gray_mode_e'(in_mode);
            last1_q <= in_last;
        end
    end

    logic [SW-1:0]    sum2_d, sum2_q;
    logic [PIX_W-1:0] max2_q;
    gray_mode_e       mode2_q;
    logic             last2_q;

    assign sum2_d = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + RND;

    // Stage 2 register: rounded sum of products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum2_q  <= '0;
            max2_q  <= '0;
            mode2_q <= GRAY_WEIGHTED;
            last2_q <= 1'b0;
        end else if (adv[1]) begin
            sum2_q  <= sum2_d;
            max2_q  <= max1_q;
            mode2_q <= mode1_q;
            last2_q <= last1_q;
        end
    end

    logic [SHW-1:0]   shifted;
    logic [PIX_W-1:0] gray_d, gray_q;
    logic             last3_q;

    // Stage 3 next state: drop fraction, clamp, or pick the maximum.
    always_comb begin
        shifted = sum2_q[SW-1:COEF_FRAC];
        if (mode2_q == GRAY_MAX) begin
            gray_d = max2_q;
        end else if (|shifted[SHW-1:PIX_W]) begin
            gray_d = '1;
        end else begin
            gray_d = shifted[PIX_W-1:0];
        end
    end

    // Stage 3 register: output beat, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q  <= '0;
            last3_q <= 1'b0;
        end else if (adv[2]) begin
            gray_q  <= gray_d;
            last3_q <= last2_q;
        end
    end

    assign out_valid = valid[2];
    assign out_gray  = gray_q;
    assign out_last  = last3_q;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed bench for rgb2gray_stream: default weights plus an
// all-8 weight instance that exercises saturation.
module tb_rgb2gray_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_rgb;
    logic        in_mode;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_gray;
    logic        out_last;

    logic        in_ready8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out_gray8;
    logic        out_last8;

    int nvec = 0;
    int nmis = 0;

    logic [23:0] v_rgb  [16];
    bit          v_mode [16];
    bit          v_last [16];
    int          v_exp  [16];
    int          v_exp8 [16];

    rgb2gray_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rgb   (in_rgb),
        .in_mode  (in_mode),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_gray (out_gray),
        .out_last (out_last)
    );

    rgb2gray_stream #(
        .COEF_R(8),
        .COEF_G(8),
        .COEF_B(8)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready8),
        .in_rgb   (in_rgb),
        .in_mode  (in_mode),
        .in_last  (in_last),
        .out_valid(out_valid8),
        .out_ready(out_ready8),
        .out_gray (out_gray8),
        .out_last (out_last8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [23:0] rgb,
                           input bit m, input bit l,
                           input int e, input int e8);
        v_rgb[i]  = rgb;
        v_mode[i] = m;
        v_last[i] = l;
        v_exp[i]  = e;
        v_exp8[i] = e8;
    endtask

    // One beat into an empty pipe: accepted at edge N, out_valid is
    // first seen after edge N+2 and consumed at edge N+3.
    task automatic lat(input logic [23:0] rgb, input bit m,
                       input int e, input int e8);
        int w = 0;
        @(negedge clk);
        in_rgb    = rgb;
        in_mode   = m;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        while (!in_ready && w < 5) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("lat_rdy", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk) check("lat_c1", out_valid, 0);
        @(negedge clk) check("lat_c2", out_valid, 0);
        @(negedge clk);
        check("lat_c3", out_valid, 1);
        check("lat_gray", out_gray, e);
        check("lat_v8", out_valid8, 1);
        check("lat_gray8", out_gray8, e8);
        @(negedge clk) check("lat_end", out_valid, 0);
    endtask

    // Stream n table beats with an out_ready pattern and scoreboard.
    task automatic stream(input int n, input logic [15:0] pat,
                          input bit do8);
        int ni = 0;
        int no = 0;
        int n8 = 0;
        int occ = 0;
        int cyc = 0;
        bit hold = 1'b0;
        int hg = 0;
        int hl = 0;
        while ((no < n || (do8 && n8 < n)) && cyc < 300) begin
            @(negedge clk);
            if (hold) begin
                check("hold_v", out_valid, 1);
                check("hold_gray", out_gray, hg);
                check("hold_last", out_last, hl);
            end
            out_ready = pat[cyc%16];
            in_valid  = (ni < n);
            if (ni < n) begin
                in_rgb  = v_rgb[ni];
                in_mode = v_mode[ni];
                in_last = v_last[ni];
            end
            #1;
            check("in_ready", in_ready,
                  (occ < 3 || out_ready) ? 1 : 0);
            hold = out_valid && !out_ready;
            hg   = out_gray;
            hl   = out_last;
            if (out_valid && out_ready) begin
                if (no < n) begin
                    check($sformatf("gray[%0d]", no), out_gray, v_exp[no]);
                    check($sformatf("last[%0d]", no), out_last,
                          v_last[no]);
                end else begin
                    check("dup", 1, 0);
                end
                no++;
                occ--;
            end
            if (do8 && out_valid8) begin
                if (n8 < n) begin
                    check($sformatf("gray8[%0d]", n8), out_gray8,
                          v_exp8[n8]);
                end
                n8++;
            end
            if (in_valid && in_ready) begin
                ni++;
                occ++;
            end
            cyc++;
        end
        check("delivered", no, n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk) check("drain", out_valid, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_rgb     = '0;
        in_mode    = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        out_ready8 = 1'b1;

        #12;
        check("rst_valid", out_valid, 0);
        check("rst_gray", out_gray, 0);
        check("rst_last", out_last, 0);
        check("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_ready0", in_ready, 0);
        @(negedge clk) check("rel_ready1", in_ready, 1);

        lat(24'h646464, 1'b0, 100, 150);

        set_vec(0, 24'hFF0000, 1'b0, 1'b0,  80, 128);
        set_vec(1, 24'hFFFFFF, 1'b0, 1'b0, 255, 255);
        set_vec(2, 24'h0A0A0A, 1'b0, 1'b0,  10,  15);
        set_vec(3, 24'h0CC825, 1'b1, 1'b0, 200, 200);
        set_vec(4, 24'h0CC825, 1'b0, 1'b1, 121, 125);
        set_vec(5, 24'h0CC825, 1'b1, 1'b0, 200, 200);
        set_vec(6, 24'h000000, 1'b0, 1'b0,   0,   0);
        set_vec(7, 24'h0000FF, 1'b1, 1'b0, 255, 255);
        stream(8, 16'hFFFF, 1'b1);

        set_vec(0, 24'h141414, 1'b0, 1'b0,  20, 0);
        set_vec(1, 24'h282828, 1'b0, 1'b0,  40, 0);
        set_vec(2, 24'h00FF00, 1'b0, 1'b0, 143, 0);
        set_vec(3, 24'h0000FF, 1'b0, 1'b1,  32, 0);
        set_vec(4, 24'h010203, 1'b1, 1'b0,   3, 0);
        set_vec(5, 24'h102030, 1'b0, 1'b0,  29, 0);
        set_vec(6, 24'hC86432, 1'b1, 1'b0, 200, 0);
        set_vec(7, 24'hC86432, 1'b0, 1'b0, 125, 0);
        set_vec(8, 24'hFFFF00, 1'b0, 1'b0, 223, 0);
        set_vec(9, 24'h070707, 1'b0, 1'b1,   7, 0);
        // out_ready bits from LSB: 1,0,0,1,0,1,1,0,0,0,1,1,0,1,0,1
        stream(10, 16'hAC69, 1'b0);

        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rgb    = 24'hFF0000;
        in_mode   = 1'b0;
        in_last   = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_gray", out_gray, 0);
        check("arst_last", out_last, 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 check("rerel_ready0", in_ready, 0);
        repeat (4) @(negedge clk) check("stale", out_valid, 0);
        lat(24'h0CC825, 1'b0, 121, 125);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
